key_eeprom_reader: RTL



---
 rtl/key_eeprom_pkg.sv | 18 +
 rtl/spi_bit_engine.sv | 87 ++++++++
 rtl/key_eeprom_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_eeprom_pkg.sv
// Shared types and constants for the key EEPROM reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] EE_CMD_READ = 8'h03;
  localparam int         FRAME_BITS  = 24;
  localparam int         DATA_BITS   = 8;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: sclk divider, MSB-first shift out, sample in.
// Latency: len*2*CLK_DIV cycles from start to done (done is combinational in the last cycle).
// Backpressure: none; start/load must only be issued while the engine is idle.
//
// Ports: clk/rst_n; load + load_dat preload the transmit register (MOSI shows
// its MSB immediately); start + len clock out len bits; done marks the last
// high phase; rx_dat holds the last RX_BITS bits sampled from miso.
module spi_bit_engine #(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 24,
  parameter int RX_BITS  = 8,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [MAX_BITS-1:0] load_dat,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic [RX_BITS-1:0]  rx_dat,
  output logic                done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [MAX_BITS-1:0] tx_sr;
  logic [RX_BITS-1:0]  rx_sr;
  logic                active;
  logic                sclk_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [LEN_W-1:0]    bit_cnt;
  logic [LEN_W-1:0]    len_q;
  logic                phase_end;
  logic                last_bit;
  logic                capture;

  assign phase_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == len_q - LEN_W'(1));
  // Only the trailing RX_BITS bits of a frame are the data phase.
  assign capture   = (bit_cnt >= len_q - LEN_W'(RX_BITS));
  assign done      = phase_end && sclk_q && last_bit;

  assign sclk   = sclk_q;
  assign mosi   = tx_sr[MAX_BITS-1];
  assign rx_dat = rx_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      active  <= 1'b0;
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
    end else if (start) begin
      active  <= 1'b1;
      sclk_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      len_q   <= len;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sclk_q) begin
          // Rising edge: sample MISO on the same clk edge sclk goes high.
          sclk_q <= 1'b1;
          if (capture) rx_sr <= {rx_sr[RX_BITS-2:0], miso};
        end else begin
          // Falling edge: advance MOSI to the next bit.
          sclk_q  <= 1'b0;
          tx_sr   <= {tx_sr[MAX_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + LEN_W'(1);
          if (last_bit) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end else if (load) begin
      tx_sr <= load_dat;
    end
  end

endmodule

// File: rtl/key_eeprom_reader.sv
// Byte reads of a 128-byte 25xx010 SPI EEPROM (READ 0x03) for the auth FSM.
// Latency: request cycle 0 -> key_data_valid in cycle 50*CLK_DIV+1 (16*CLK_DIV+1 for sequential bytes).
// Backpressure: one pending slot filled during GAP; other requests are dropped with req_dropped.
//
// Ports: key_load_req/key_addr in, key_data/key_data_valid out, busy,
// req_dropped, and the SPI pins spi_sclk/spi_cs_n/spi_mosi/spi_miso.
// Optional macro KEY_EEPROM_SEQ_READ_EN: consecutive addresses continue the
// open frame with only 8 more data clocks instead of a new 24-bit frame.
module key_eeprom_reader
  import key_eeprom_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_load_req,
  input  logic [6:0] key_addr,
  output logic [7:0] key_data,
  output logic       key_data_valid,
  output logic       busy,
  output logic       req_dropped,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEN_W   = $clog2(FRAME_BITS + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cs_n_q, cs_n_nxt;
  logic [7:0]       key_data_q;
  logic             valid_q, valid_nxt;
  logic             dropped_q, drop_nxt;
  logic [6:0]       addr_q, new_addr;
  logic             pend_vld, pend_vld_nxt;
  logic [6:0]       pend_addr, pend_addr_nxt;
  logic             launch;
  logic [6:0]       launch_addr;
  logic             eng_load, eng_start, eng_done;
  logic [LEN_W-1:0] eng_len;
  logic [7:0]       eng_rx;
`ifdef KEY_EEPROM_SEQ_READ_EN
  logic             seq_open, seq_open_nxt;   // frame kept open after a byte
  logic             seq_frame, seq_frame_nxt; // current SHIFT is an 8-bit continuation
`endif

  spi_bit_engine #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BITS (FRAME_BITS),
    .RX_BITS  (DATA_BITS),
    .LEN_W    (LEN_W)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (eng_load),
    .load_dat ({EE_CMD_READ, 1'b0, new_addr, 8'h00}),
    .start    (eng_start),
    .len      (eng_len),
    .miso     (spi_miso),
    .sclk     (spi_sclk),
    .mosi     (spi_mosi),
    .rx_dat   (eng_rx),
    .done     (eng_done)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CNT_W'(1);
    cs_n_nxt      = cs_n_q;
    valid_nxt     = 1'b0;
    drop_nxt      = key_load_req && (state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    new_addr      = addr_q;
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    launch        = 1'b0;
    launch_addr   = key_addr;
    eng_load      = 1'b0;
    eng_start     = 1'b0;
    eng_len       = LEN_W'(FRAME_BITS);
`ifdef KEY_EEPROM_SEQ_READ_EN
    seq_open_nxt  = seq_open;
    seq_frame_nxt = seq_frame;
`endif
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        launch  = key_load_req;
      end
      ST_SETUP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          eng_start = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cnt_nxt = '0;
        if (eng_done) begin
`ifdef KEY_EEPROM_SEQ_READ_EN
          if (seq_frame) begin
            // Continuation bytes have no HOLD: report as soon as bits are in.
            valid_nxt     = 1'b1;
            seq_frame_nxt = 1'b0;
            state_nxt     = ST_GAP;
            if (addr_q == 7'h7F) cs_n_nxt = 1'b1;
            else                 seq_open_nxt = 1'b1;
          end else
`endif
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cs_n_nxt  = 1'b1;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
`ifdef KEY_EEPROM_SEQ_READ_EN
          if (addr_q != 7'h7F) begin
            cs_n_nxt     = 1'b0;
            seq_open_nxt = 1'b1;
          end
`endif
        end
      end
      ST_GAP: begin
`ifdef KEY_EEPROM_SEQ_READ_EN
        if (seq_open) begin
          if (key_load_req && key_addr == 7'(addr_q + 7'd1)) begin
            new_addr      = key_addr;
            eng_start     = 1'b1;
            eng_len       = LEN_W'(DATA_BITS);
            seq_frame_nxt = 1'b1;
            seq_open_nxt  = 1'b0;
            state_nxt     = ST_SHIFT;
          end else if (key_load_req) begin
            // Non-consecutive: close the frame and serve it after a full gap.
            pend_vld_nxt  = 1'b1;
            pend_addr_nxt = key_addr;
            cs_n_nxt      = 1'b1;
            seq_open_nxt  = 1'b0;
            cnt_nxt       = '0;
          end else if (cnt == CNT_W'(CS_GAP - 1)) begin
            cs_n_nxt     = 1'b1;
            seq_open_nxt = 1'b0;
            cnt_nxt      = '0;
          end
        end else
`endif
        begin
          if (key_load_req) begin
            if (pend_vld) begin
              drop_nxt = 1'b1;
            end else begin
              pend_vld_nxt  = 1'b1;
              pend_addr_nxt = key_addr;
            end
          end
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            // A request in the final gap cycle is launched directly.
            if (pend_vld || key_load_req) begin
              launch       = 1'b1;
              launch_addr  = pend_vld ? pend_addr : key_addr;
              pend_vld_nxt = 1'b0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (launch) begin
      new_addr  = launch_addr;
      eng_load  = 1'b1;
      cs_n_nxt  = 1'b0;
      cnt_nxt   = '0;
      state_nxt = ST_SETUP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cs_n_q     <= 1'b1;
      key_data_q <= 8'h00;
      valid_q    <= 1'b0;
      dropped_q  <= 1'b0;
      addr_q     <= '0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
`ifdef KEY_EEPROM_SEQ_READ_EN
      seq_open   <= 1'b0;
      seq_frame  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cs_n_q    <= cs_n_nxt;
      valid_q   <= valid_nxt;
      dropped_q <= drop_nxt;
      addr_q    <= new_addr;
      pend_vld  <= pend_vld_nxt;
      pend_addr <= pend_addr_nxt;
      if (valid_nxt) key_data_q <= eng_rx;
`ifdef KEY_EEPROM_SEQ_READ_EN
      seq_open  <= seq_open_nxt;
      seq_frame <= seq_frame_nxt;
`endif
    end
  end

  assign spi_cs_n       = cs_n_q;
  assign key_data       = key_data_q;
  assign key_data_valid = valid_q;
  assign req_dropped    = dropped_q;
  assign busy           = (state != ST_IDLE);

endmodule
